lfsr_gen: RTL

LFSR_GEN -- requirements
Module: lfsr_gen

---
 rtl/lfsr_gen_if.sv | 31 +++
 rtl/lfsr_gen.sv | 106 ++++++++++
 2 files changed

// File: rtl/lfsr_gen_if.sv
// Control and status bundle between an LFSR generator and its user.
// Latency: none; wiring only.
// Backpressure: none; the generator never stalls its user.
interface lfsr_gen_if #(
   parameter int WIDTH = 10,
   parameter int CNTW  = 8
);
   logic             en;
   logic             load;
   logic [WIDTH-1:0] seed;
   logic             start;
   logic [CNTW-1:0]  nsteps;
   logic [WIDTH-1:0] thresh;
   logic [WIDTH-1:0] q;
   logic             busy;
   logic             done;
   logic             lock_err;
   logic             lt;

   // User side: drives commands, observes state and flags.
   modport master (
      output en, load, seed, start, nsteps, thresh,
      input  q, busy, done, lock_err, lt
   );

   // Generator side.
   modport slave (
      input  en, load, seed, start, nsteps, thresh,
      output q, busy, done, lock_err, lt
   );
endinterface

// File: rtl/lfsr_gen.sv
// XNOR-feedback LFSR with free-run, seed load and counted burst modes.
// Latency: q updates one cycle after the advancing command; done/lock_err pulse one cycle after the event.
// Backpressure: none; a start arriving during a burst is dropped, and busy flags the burst window.
module lfsr_gen #(
   parameter int               WIDTH = 10,
   parameter logic [WIDTH-1:0] TAPS  = WIDTH'(10'h240),
   parameter int               STEP  = 1,
   parameter int               CNTW  = 8
) (
   input logic        clk,
   input logic        r,
   lfsr_gen_if.slave  bus
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [CNTW-1:0]  cnt_q, cnt_d;
   logic             busy_q;
   logic             done_q, done_d;
   logic             lerr_q, lerr_d;
   logic [WIDTH-1:0] q_adv;

   // One advance = STEP single XNOR shifts chained combinationally.
   function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] s);
      logic [WIDTH-1:0] t;
      t = s;
      for (int i = 0; i < STEP; i++) begin
         t = {t[WIDTH-2:0], ~^(t & TAPS)};
      end
      return t;
   endfunction

   assign q_adv = advance(q_q);

   // Next-state selection; priority is load, then an active burst, then start, then free-run.
   always_comb begin
      state_d = state_q;
      q_d     = q_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      lerr_d  = 1'b0;
      if (bus.load) begin
         // All-ones would freeze an XNOR LFSR, so it is replaced by zero and flagged.
         if (&bus.seed) begin
            q_d    = '0;
            lerr_d = 1'b1;
         end else begin
            q_d = bus.seed;
         end
         state_d = IDLE;
         cnt_d   = '0;
      end else if (state_q == RUN) begin
         q_d = q_adv;
         if (cnt_q == CNTW'(1)) begin
            state_d = IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
         end else begin
            cnt_d = cnt_q - CNTW'(1);
         end
      end else if (bus.start) begin
         if (bus.nsteps != '0) begin
            // First advance happens on the accepting cycle; the counter tracks the rest.
            q_d   = q_adv;
            cnt_d = bus.nsteps - CNTW'(1);
            if (bus.nsteps == CNTW'(1)) begin
               done_d = 1'b1;
            end else begin
               state_d = RUN;
            end
         end else begin
            done_d = 1'b1;
         end
      end else if (bus.en) begin
         q_d = q_adv;
      end
   end

   // State and registered outputs; reset overrides every other input.
   always_ff @(posedge clk) begin
      if (r) begin
         state_q <= IDLE;
         q_q     <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         lerr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         cnt_q   <= cnt_d;
         busy_q  <= (state_d == RUN);
         done_q  <= done_d;
         lerr_q  <= lerr_d;
      end
   end

   assign bus.q        = q_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.lock_err = lerr_q;
   assign bus.lt       = (q_q < bus.thresh);

endmodule
